// File: rtl/alu_acc_core_pkg.sv
// Shared definitions for the accumulator ALU core: opcode map, FSM states and opcode helpers.
// The CPU sequencer imports the same package so opcode values stay in one place.
package alu_acc_core_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_SHL  = 4'h2;
    localparam logic [3:0] OP_CMP  = 4'h3;
    localparam logic [3:0] OP_EXOR = 4'h4;
    localparam logic [3:0] OP_BCMP = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_NAND = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_NOR  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_ROL  = 4'hB;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic isShiftOp(input logic [3:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL);
    endfunction

    function automatic logic isIllegalOp(input logic [3:0] op);
        return op >= 4'hC;
    endfunction

endpackage

// File: rtl/alu_acc_core_comb.sv
// Combinational single-cycle datapath: result, carry/borrow and signed overflow for
// the arithmetic, compare and logic opcodes. Shifts and illegal opcodes yield zeros.
module alu_acc_core_comb
    import alu_acc_core_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] operand_i,
    input  logic [3:0]       opcode_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] cmpDiff;

    // One extra bit on top carries the ADD carry / SUB borrow out.
    assign sum     = {1'b0, acc_i} + {1'b0, operand_i} + {{WIDTH{1'b0}}, cin_i};
    assign diff    = {1'b0, acc_i} - {1'b0, operand_i} - {{WIDTH{1'b0}}, cin_i};
    assign cmpDiff = {1'b0, acc_i} - {1'b0, operand_i};

    always_comb begin
        result_o = '0;
        cout_o   = 1'b0;
        ovf_o    = 1'b0;
        case (opcode_i)
            OP_ADD: begin
                result_o = sum[MSB:0];
                cout_o   = sum[WIDTH];
                ovf_o    = (acc_i[MSB] == operand_i[MSB]) && (sum[MSB] != acc_i[MSB]);
            end
            OP_SUB: begin
                result_o = diff[MSB:0];
                cout_o   = diff[WIDTH];
                ovf_o    = (acc_i[MSB] != operand_i[MSB]) && (diff[MSB] != acc_i[MSB]);
            end
            // CMP reports the difference so the top can derive zero/neg; ACC is not written.
            OP_CMP: begin
                result_o = cmpDiff[MSB:0];
                cout_o   = cmpDiff[WIDTH];
                ovf_o    = (acc_i[MSB] != operand_i[MSB]) && (cmpDiff[MSB] != acc_i[MSB]);
            end
            OP_EXOR: result_o = acc_i ^ operand_i;
            OP_BCMP: result_o = ~acc_i;
            OP_AND:  result_o = acc_i & operand_i;
            OP_NAND: result_o = ~(acc_i & operand_i);
            OP_OR:   result_o = acc_i | operand_i;
            OP_NOR:  result_o = ~(acc_i | operand_i);
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_acc_core.sv
// Accumulator ALU core: holds ACC and registered flags, runs single-cycle ops through
// alu_acc_core_comb and multi-bit shifts one bit per enabled cycle under start/busy/done.
module alu_acc_core
    import alu_acc_core_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ce_i,
    input  logic             load_i,
    input  logic             start_i,
    input  logic [3:0]       opcode_i,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic [SHW-1:0]   shamt_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] data_out_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             cout_o,
    output logic             zero_o,
    output logic             neg_o,
    output logic             ovf_o,
    output logic             err_o
);

    localparam int MSB = WIDTH - 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   shiftCnt_q, shiftCnt_d;
    logic [3:0]       shiftOp_q, shiftOp_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] aluResult;
    logic             aluCout;
    logic             aluOvf;
    logic [3:0]       stepOp;
    logic [WIDTH-1:0] stepAcc;
    logic             stepOut;

    // Returns {bit shifted out, shifted value}; for ROL the bit out is the one wrapped.
    function automatic logic [WIDTH:0] shiftStep(input logic [WIDTH-1:0] v, input logic [3:0] op);
        logic [WIDTH:0] r;
        r = {v[MSB], v[MSB-1:0], 1'b0};
        case (op)
            OP_SHR:  r = {v[0], 1'b0, v[MSB:1]};
            OP_ROL:  r = {v[MSB], v[MSB-1:0], v[MSB]};
            default: ;
        endcase
        return r;
    endfunction

    alu_acc_core_comb #(.WIDTH(WIDTH)) u_comb (
        .acc_i     (acc_q),
        .operand_i (data_in_i),
        .opcode_i  (opcode_i),
        .cin_i     (cin_i),
        .result_o  (aluResult),
        .cout_o    (aluCout),
        .ovf_o     (aluOvf)
    );

    assign stepOp             = (state_q == ST_SHIFT) ? shiftOp_q : opcode_i;
    assign {stepOut, stepAcc} = shiftStep(acc_q, stepOp);

    // SHIFT stays entered through the done cycle (counter at zero) so a new start
    // cannot slip in while busy is still reported.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        shiftCnt_d = shiftCnt_q;
        shiftOp_d  = shiftOp_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        cout_d     = cout_q;
        zero_d     = zero_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        if (ce_i) begin
            done_d = 1'b0;
            err_d  = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_i) begin
                        acc_d = data_in_i;
                    end else if (start_i) begin
                        done_d = 1'b1;
                        if (isIllegalOp(opcode_i)) begin
                            err_d = 1'b1;
                        end else if (isShiftOp(opcode_i)) begin
                            if (shamt_i == '0) begin
                                cout_d = 1'b0;
                                ovf_d  = 1'b0;
                                zero_d = (acc_q == '0);
                                neg_d  = acc_q[MSB];
                            end else begin
                                acc_d      = stepAcc;
                                shiftOp_d  = opcode_i;
                                shiftCnt_d = shamt_i - SHW'(1);
                                state_d    = ST_SHIFT;
                                busy_d     = 1'b1;
                                done_d     = (shamt_i == SHW'(1));
                                if (shamt_i == SHW'(1)) begin
                                    cout_d = stepOut;
                                    ovf_d  = 1'b0;
                                    zero_d = (stepAcc == '0);
                                    neg_d  = stepAcc[MSB];
                                end
                            end
                        end else begin
                            if (opcode_i != OP_CMP) begin
                                acc_d = aluResult;
                            end
                            cout_d = aluCout;
                            ovf_d  = aluOvf;
                            zero_d = (aluResult == '0);
                            neg_d  = aluResult[MSB];
                        end
                    end
                end
                ST_SHIFT: begin
                    if (shiftCnt_q == '0) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        acc_d      = stepAcc;
                        shiftCnt_d = shiftCnt_q - SHW'(1);
                        done_d     = (shiftCnt_q == SHW'(1));
                        if (shiftCnt_q == SHW'(1)) begin
                            cout_d = stepOut;
                            ovf_d  = 1'b0;
                            zero_d = (stepAcc == '0);
                            neg_d  = stepAcc[MSB];
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            shiftCnt_q <= '0;
            shiftOp_q  <= OP_SHL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cout_q     <= 1'b0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            shiftCnt_q <= shiftCnt_d;
            shiftOp_q  <= shiftOp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cout_q     <= cout_d;
            zero_q     <= zero_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
        end
    end

    // A pending pulse is masked while ce is low and shows in the next enabled cycle.
    assign done_o     = done_q & ce_i;
    assign err_o      = err_q & ce_i;
    assign data_out_o = acc_q;
    assign busy_o     = busy_q;
    assign cout_o     = cout_q;
    assign zero_o     = zero_q;
    assign neg_o      = neg_q;
    assign ovf_o      = ovf_q;

endmodule
